// File: rtl/wboled_fifo_if.sv
// Wishbone slave bus bundle for the OLED SPI controller.
interface wboled_fifo_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic        stall;
  logic [31:0] rdata;

  modport master (output cyc, stb, we, addr, wdata, input ack, stall, rdata);
  modport slave  (input cyc, stb, we, addr, wdata, output ack, stall, rdata);
endinterface

// File: rtl/wboled_fifo.sv
// Wishbone SPI display controller: command/data byte FIFO feeding a mode-3
// serializer with programmable SCK half-period, power bits and idle interrupt.
//
// state    | meaning
// S_IDLE   | CSn high, waiting for a queued byte
// S_SETUP  | CSn low, SCK high, ckdiv cycles before the first falling edge
// S_SHIFT  | shifting 8 bits MSB first, SCK toggles every ckdiv cycles
// S_HOLD_A | after last rising edge, CSn still low for ckdiv cycles
// S_HOLD_B | CSn high minimum time before a new frame may start
module wboled_fifo #(
  parameter int          LGFIFO        = 5,
  parameter logic [7:0]  DEFAULT_CKDIV = 8'd4
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  wboled_fifo_if.slave   wb,
  output logic           o_sck,
  output logic           o_mosi,
  output logic           o_dcn,
  output logic           o_csn,
  output logic [2:0]     o_pwr,
  output logic           o_int
);

  localparam int DEPTH = 1 << LGFIFO;
  localparam logic [LGFIFO-1:0] PTR_ONE  = 1;
  localparam logic [LGFIFO:0]   FILL_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD_A, S_HOLD_B} state_t;

  logic [8:0]        mem [DEPTH];
  logic [LGFIFO-1:0] wr_ptr, rd_ptr;
  logic [LGFIFO:0]   fill;
  logic              empty, full;
  logic              overflow;
  logic [7:0]        ckdiv, ckdiv_eff, reload;
  logic              skid_vld;
  logic [8:0]        skid_data;
  state_t            state;
  logic [7:0]        cnt;
  logic [7:0]        sreg;
  logic [2:0]        bitn;
  logic [8:0]        head;

  logic       bus_wr, bus_push, split, push_req, push_ok, bus_lost, ovf_set, pop, at_last_rise;
  logic [8:0] bus_entry, push_entry;
  logic [31:0] status;
  logic       unused_bits;

  assign unused_bits = &{1'b0, wb.cyc, wb.wdata[30:20]};

  assign empty     = (fill == '0);
  assign full      = fill[LGFIFO];
  assign ckdiv_eff = (ckdiv == 8'd0) ? 8'd1 : ckdiv;
  assign reload    = ckdiv_eff - 8'd1;
  assign head      = mem[rd_ptr];

  always_comb begin
    bus_wr    = wb.stb && wb.we;
    bus_push  = bus_wr && ((wb.addr == 2'd1) || (wb.addr == 2'd2));
    split     = bus_wr && (wb.addr == 2'd2) && wb.wdata[31];
    bus_entry = split ? {1'b1, wb.wdata[15:8]} : {(wb.addr == 2'd2), wb.wdata[7:0]};
    // The pending skid byte owns the push slot; a bus push colliding with it is lost.
    push_req   = skid_vld || bus_push;
    push_entry = skid_vld ? skid_data : bus_entry;
    bus_lost   = skid_vld && bus_push;
    at_last_rise = (state == S_SHIFT) && !o_sck && (cnt == 8'd0) && (bitn == 3'd7);
    pop        = !empty && ((state == S_IDLE) || at_last_rise);
    push_ok    = push_req && (!full || pop);
    ovf_set    = (push_req && !push_ok) || bus_lost;
  end

  assign status = {{(7-LGFIFO){1'b0}}, fill, 5'h0, o_pwr, ckdiv, 3'h0,
                   overflow, o_int, empty, full, (state != S_IDLE)};

  assign wb.stall = 1'b0;

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   fill <= fill + FILL_ONE;
        2'b01:   fill <= fill - FILL_ONE;
        default: fill <= fill;
      endcase
      if (split && !skid_vld) begin
        skid_vld  <= 1'b1;
        skid_data <= {1'b1, wb.wdata[7:0]};
      end else begin
        skid_vld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wb.ack   <= 1'b0;
      wb.rdata <= '0;
      overflow <= 1'b0;
      o_pwr    <= '0;
      ckdiv    <= DEFAULT_CKDIV;
      o_int    <= 1'b0;
    end else begin
      wb.ack   <= wb.stb;
      wb.rdata <= (wb.stb && !wb.we && (wb.addr == 2'd0)) ? status : 32'h0;
      if (ovf_set)
        overflow <= 1'b1;
      else if (bus_wr && (wb.addr == 2'd0) && wb.wdata[4])
        overflow <= 1'b0;
      if (bus_wr && (wb.addr == 2'd3)) begin
        for (int i = 0; i < 3; i++)
          if (wb.wdata[16+i]) o_pwr[i] <= wb.wdata[i];
        if (wb.wdata[19]) ckdiv <= wb.wdata[15:8];
      end
      o_int <= empty && (state == S_IDLE) && !push_ok;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= S_IDLE;
      o_sck  <= 1'b1;
      o_mosi <= 1'b0;
      o_dcn  <= 1'b0;
      o_csn  <= 1'b1;
      cnt    <= '0;
      sreg   <= '0;
      bitn   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            sreg  <= head[7:0];
            o_dcn <= head[8];
            o_csn <= 1'b0;
            cnt   <= reload;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == 8'd0) begin
            o_sck  <= 1'b0;
            o_mosi <= sreg[7];
            sreg   <= {sreg[6:0], 1'b0};
            bitn   <= 3'd0;
            cnt    <= reload;
            state  <= S_SHIFT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_SHIFT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (!o_sck) begin
            o_sck <= 1'b1;
            cnt   <= reload;
            // Next byte is loaded on the last rising edge so dcn settles while SCK is high.
            if (bitn == 3'd7) begin
              if (!empty) begin
                sreg  <= head[7:0];
                o_dcn <= head[8];
              end else begin
                state <= S_HOLD_A;
              end
            end
          end else begin
            o_sck  <= 1'b0;
            o_mosi <= sreg[7];
            sreg   <= {sreg[6:0], 1'b0};
            bitn   <= bitn + 3'd1;
            cnt    <= reload;
          end
        end
        S_HOLD_A: begin
          if (cnt == 8'd0) begin
            o_csn <= 1'b1;
            cnt   <= reload;
            state <= S_HOLD_B;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_HOLD_B: begin
          if (cnt == 8'd0) state <= S_IDLE;
          else             cnt   <= cnt - 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wboled_fifo.sv
// Directed bench for wboled_fifo: SPI frame monitor against an expected byte
// queue, per-cycle bus/power checks, and literal status expectations.
module tb_wboled_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck, mosi, dcn, csn, intr;
  logic [2:0] pwr;

  always #5 clk = ~clk;

  wboled_fifo_if wb();

  wboled_fifo #(.LGFIFO(5), .DEFAULT_CKDIV(8'd4)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .wb        (wb),
    .o_sck     (sck),
    .o_mosi    (mosi),
    .o_dcn     (dcn),
    .o_csn     (csn),
    .o_pwr     (pwr),
    .o_int     (intr)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [2:0] m_pwr = 3'b000;
  logic [7:0] m_ckdiv = 8'd4;
  logic [8:0] exp_q[$];

  int         n_bytes = 0, csn_rises = 0, sck_rises = 0;
  logic [8:0] last_rx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int div_eff();
    return (m_ckdiv == 8'd0) ? 1 : int'(m_ckdiv);
  endfunction

  // Per-cycle bus and power-bit checks.
  logic exp_ack = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_ack = 1'b0;
    end else begin
      check("ack", 32'(wb.ack), 32'(exp_ack));
      check("stall", 32'(wb.stall), 32'h0);
      check("pwr", 32'(pwr), 32'(m_pwr));
      if (csn) check("sck_idle_high", 32'(sck), 32'h1);
      exp_ack = wb.stb;
    end
  end

  // SPI monitor: mode 3, MSB first, edges every ckdiv cycles.
  logic       p_sck = 1'b1, p_csn = 1'b1, hi_valid = 1'b0;
  int         bitc = 0, last_evt = 0, csn_hi_at = 0;
  logic [7:0] sh = '0;
  logic       cur_dcn = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      bitc = 0; p_sck = 1'b1; p_csn = 1'b1; hi_valid = 1'b0;
    end else begin
      if (p_csn && !csn) begin
        last_evt = cyc;
        if (hi_valid) check("csn_high_min", 32'((cyc - csn_hi_at) >= div_eff()), 32'h1);
      end
      if (!p_csn && csn) begin
        csn_rises++;
        check("csn_hold", 32'(cyc - last_evt), 32'(div_eff()));
        check("csn_rise_on_byte", 32'(bitc), 32'h0);
        csn_hi_at = cyc;
        hi_valid = 1'b1;
      end
      if (!p_sck && sck) sck_rises++;
      if (!p_sck && sck && !csn) begin
        check("sck_period", 32'(cyc - last_evt), 32'(2 * div_eff()));
        last_evt = cyc;
        if (bitc == 0) cur_dcn = dcn;
        sh = {sh[6:0], mosi};
        bitc++;
        if (bitc == 8) begin
          bitc = 0;
          n_bytes++;
          last_rx = {cur_dcn, sh};
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL extra_byte: got %h expected none", {cur_dcn, sh});
          end else begin
            check("spi_byte", 32'({cur_dcn, sh}), 32'(exp_q.pop_front()));
          end
        end
      end
      p_sck = sck;
      p_csn = csn;
    end
  end

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1; wb.addr = a; wb.wdata = d;
    @(posedge clk); #1;
    wb.stb = 1'b0; wb.we = 1'b0;
    if (a == 2'd3) begin
      for (int i = 0; i < 3; i++) if (d[16+i]) m_pwr[i] = d[i];
      if (d[19]) m_ckdiv = d[15:8];
    end
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.addr = a;
    @(posedge clk); #1;
    wb.stb = 1'b0;
    d = wb.rdata;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] s;
    int n;
    n = 0;
    s = '0;
    while (n < budget) begin
      wb_read(2'd0, s);
      if (!s[0] && s[2]) break;
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: got status %h expected idle within %0d reads", s, budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    int nb0, cr0, sr0;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.addr = '0; wb.wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", 32'(sck), 32'h1);
    check("rst_csn", 32'(csn), 32'h1);
    check("rst_mosi", 32'(mosi), 32'h0);
    check("rst_dcn", 32'(dcn), 32'h0);
    check("rst_pwr", 32'(pwr), 32'h0);
    check("rst_int", 32'(intr), 32'h0);
    check("rst_ack", 32'(wb.ack), 32'h0);
    check("rst_rdata", wb.rdata, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("int_after_reset", 32'(intr), 32'h1);
    wb_read(2'd0, s);
    check("status_reset", s, 32'h0000_040C);

    wb_write(2'd3, 32'h0001_0001);
    check("pwr_set0", 32'(pwr), 32'h1);
    wb_write(2'd3, 32'h0000_0001);
    check("pwr_noen", 32'(pwr), 32'h1);
    wb_write(2'd3, 32'h0007_0005);
    check("pwr_all", 32'(pwr), 32'h5);
    wb_read(2'd1, s);
    check("read_addr1", s, 32'h0);
    wb_read(2'd0, s);
    check("status_pwr", s, 32'h0005_040C);

    // Single command byte
    nb0 = n_bytes;
    exp_q.push_back(9'h0AF);
    wb_write(2'd1, 32'h0000_00AF);
    check("int_drop_on_push", 32'(intr), 32'h0);
    wait_idle(200);
    repeat (2) @(posedge clk);
    #1;
    check("int_return", 32'(intr), 32'h1);
    check("cmd_af_count", 32'(n_bytes - nb0), 32'h1);
    check("cmd_af_byte", 32'(last_rx), 32'h0AF);

    // Split data write plus command, one CSn frame
    nb0 = n_bytes; cr0 = csn_rises;
    exp_q.push_back(9'h112);
    exp_q.push_back(9'h134);
    exp_q.push_back(9'h05A);
    wb_write(2'd2, 32'h8000_1234);
    wb_write(2'd1, 32'h0000_005A);
    wait_idle(400);
    check("burst_count", 32'(n_bytes - nb0), 32'h3);
    check("burst_one_frame", 32'(csn_rises - cr0), 32'h1);
    check("burst_last", 32'(last_rx), 32'h05A);
    check("burst_q_empty", 32'(exp_q.size()), 32'h0);

    // Overflow: 34 back-to-back pushes, 33 survive
    nb0 = n_bytes;
    for (int i = 0; i < 33; i++) exp_q.push_back({1'b0, 8'(8'hC0 + i)});
    @(posedge clk); #1;
    wb.stb = 1'b1; wb.we = 1'b1; wb.addr = 2'd1;
    for (int i = 0; i < 34; i++) begin
      wb.wdata = 32'(8'(8'hC0 + i));
      @(posedge clk); #1;
    end
    wb.stb = 1'b0; wb.we = 1'b0;
    wb_read(2'd0, s);
    check("status_full_ovf", s, 32'h2005_0413);
    wb_write(2'd0, 32'h0000_0010);
    wb_read(2'd0, s);
    check("ovf_cleared", 32'(s[4]), 32'h0);
    wait_idle(2000);
    check("ovf_count", 32'(n_bytes - nb0), 32'd33);
    check("ovf_last", 32'(last_rx), 32'h0E0);
    check("ovf_q_empty", 32'(exp_q.size()), 32'h0);

    // ckdiv=0 behaves as 1
    wb_write(2'd3, 32'h0008_0000);
    wb_read(2'd0, s);
    check("ckdiv_zero_field", 32'(s[15:8]), 32'h0);
    nb0 = n_bytes;
    exp_q.push_back(9'h13C);
    wb_write(2'd2, 32'h0000_003C);
    wait_idle(100);
    check("div1_count", 32'(n_bytes - nb0), 32'h1);
    check("div1_byte", 32'(last_rx), 32'h13C);
    wb_write(2'd3, 32'h0008_0400);

    // Asynchronous reset mid-byte
    exp_q.push_back(9'h1A5);
    wb_write(2'd2, 32'h0000_00A5);
    repeat (20) @(posedge clk);
    #2;
    check("pre_reset_csn_low", 32'(csn), 32'h0);
    rst_n = 1'b0;
    #1;
    check("async_sck", 32'(sck), 32'h1);
    check("async_csn", 32'(csn), 32'h1);
    exp_q.delete();
    m_pwr = 3'b000;
    m_ckdiv = 8'd4;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nb0 = n_bytes; sr0 = sck_rises;
    wb_read(2'd0, s);
    check("post_reset_fill", 32'(s[31:24]), 32'h0);
    check("post_reset_status", s, 32'h0000_040C);
    repeat (200) @(posedge clk);
    #1;
    check("no_sck_after_reset", 32'(sck_rises - sr0), 32'h0);
    check("no_bytes_after_reset", 32'(n_bytes - nb0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
